// File: rtl/imm_chunker_if.sv
// Handshake bundle for imm_chunker: constant input side plus chunk output side.
// master = constant source / chunk consumer, slave = the encoder.
interface imm_chunker_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_chunk;
  logic       out_first;
  logic       out_last;
  logic [1:0] out_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_chunk, out_first, out_last, out_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_chunk, out_first, out_last, out_count
  );
endinterface

// File: rtl/imm_chunker.sv
// Splits an 8-bit signed constant into the minimal MS-first sequence of 3-bit
// chunks that sign-extend-then-shift-append reconstructs.
module imm_chunker (
  input  logic        clk,
  input  logic        reset_n,
  imm_chunker_if.slave bus
);
  typedef enum logic {IDLE, EMIT} state_t;

  state_t     state, state_n;
  logic [8:0] x, x_n;
  logic [1:0] n, n_n;
  logic [1:0] idx, idx_n;
  logic [1:0] n_calc;
  logic [1:0] sel;
  logic       emit;
  logic       last;
  logic       in_fire;
  logic       out_fire;

  // -4..3 needs bits 7:2 all equal, -32..31 needs bits 7:5 all equal
  always_comb begin
    if (&bus.in_data[7:2] || ~|bus.in_data[7:2])
      n_calc = 2'd1;
    else if (&bus.in_data[7:5] || ~|bus.in_data[7:5])
      n_calc = 2'd2;
    else
      n_calc = 2'd3;
  end

  assign emit     = (state == EMIT);
  assign last     = emit && (idx == n - 2'd1);
  assign out_fire = emit && bus.out_ready;
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign sel      = n - idx - 2'd1;

  assign bus.in_ready  = (state == IDLE) || (out_fire && last);
  assign bus.out_valid = emit;
  assign bus.out_first = emit && (idx == 2'd0);
  assign bus.out_last  = last;
  assign bus.out_count = n;

  always_comb begin
    case (sel)
      2'd2:    bus.out_chunk = x[8:6];
      2'd1:    bus.out_chunk = x[5:3];
      default: bus.out_chunk = x[2:0];
    endcase
  end

  always_comb begin
    state_n = state;
    x_n     = x;
    n_n     = n;
    idx_n   = idx;
    // a new capture overrides the return to IDLE on a last-chunk handshake
    if (in_fire) begin
      state_n = EMIT;
      x_n     = {bus.in_data[7], bus.in_data};
      n_n     = n_calc;
      idx_n   = 2'd0;
    end else if (out_fire) begin
      if (last) begin
        state_n = IDLE;
        idx_n   = 2'd0;
      end else begin
        idx_n   = idx + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      x     <= '0;
      n     <= 2'd1;
      idx   <= '0;
    end else begin
      state <= state_n;
      x     <= x_n;
      n     <= n_n;
      idx   <= idx_n;
    end
  end
endmodule

// File: tb/tb_imm_chunker.sv
// Directed-vector bench for imm_chunker plus a full 256-value reconstruction sweep.
module tb_imm_chunker;
  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  imm_chunker_if bus ();

  imm_chunker dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [2:0] c,
                         input logic f, input logic l, input logic [1:0] cnt);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, "_chunk"}, 32'(bus.out_chunk), 32'(c));
    check({tag, "_first"}, 32'(bus.out_first), 32'(f));
    check({tag, "_last"},  32'(bus.out_last),  32'(l));
    check({tag, "_count"}, 32'(bus.out_count), 32'(cnt));
  endtask

  // Drive one constant with out_ready high; expected chunks c0 (first) .. c2.
  task automatic run_vec(input string tag, input logic [7:0] d, input int n,
                         input logic [2:0] c0, input logic [2:0] c1, input logic [2:0] c2);
    logic [2:0] exp_c [3];
    exp_c[0] = c0; exp_c[1] = c1; exp_c[2] = c2;
    @(negedge clk);
    check({tag, "_inrdy"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.out_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) bus.in_valid = 1'b0;
      chk_out(tag, 1'b1, exp_c[k], k == 0, k == n - 1, 2'(n));
    end
    @(negedge clk);
    check({tag, "_idle"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int v, got_n, exp_n, sv;
    logic done;
    checks = 0;
    errors = 0;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // reset state
    @(negedge clk);
    chk_out("rst", 1'b0, 3'b000, 1'b0, 1'b0, 2'd1);
    reset_n = 1'b1;
    #1 check("rst_inrdy", 32'(bus.in_ready), 32'd1);

    // directed vectors
    run_vec("v03", 8'h03, 1, 3'b011, 3'b000, 3'b000);
    run_vec("vFC", 8'hFC, 1, 3'b100, 3'b000, 3'b000);
    run_vec("v05", 8'h05, 2, 3'b000, 3'b101, 3'b000);
    run_vec("vE0", 8'hE0, 2, 3'b100, 3'b000, 3'b000);
    run_vec("v20", 8'h20, 3, 3'b000, 3'b100, 3'b000);
    run_vec("v80", 8'h80, 3, 3'b110, 3'b000, 3'b000);

    // backpressure on the middle chunk, then on the last chunk with input pending
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 8'h80; bus.out_ready = 1'b1;
    @(negedge clk);
    chk_out("bp_c0", 1'b1, 3'b110, 1'b1, 1'b0, 2'd3);
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1; bus.in_data = 8'h7F;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_out("bp_hold", 1'b1, 3'b000, 1'b0, 1'b0, 2'd3);
      check("bp_inrdy", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk_out("bp_c2", 1'b1, 3'b000, 1'b0, 1'b1, 2'd3);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1; bus.in_data = 8'h01;
    #1 check("bp_last_inrdy", 32'(bus.in_ready), 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk_out("bp_lhold", 1'b1, 3'b000, 1'b0, 1'b1, 2'd3);
      check("bp_lhold_inrdy", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1 check("bp_release_inrdy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    chk_out("bp_next", 1'b1, 3'b001, 1'b1, 1'b1, 2'd1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp_idle", 32'(bus.out_valid), 32'd0);

    // back-to-back constants with no bubble
    bus.in_valid = 1'b1; bus.in_data = 8'h7F; bus.out_ready = 1'b1;
    @(negedge clk);
    chk_out("b2b_0", 1'b1, 3'b001, 1'b1, 1'b0, 2'd3);
    bus.in_data = 8'h01;
    @(negedge clk);
    chk_out("b2b_1", 1'b1, 3'b111, 1'b0, 1'b0, 2'd3);
    @(negedge clk);
    chk_out("b2b_2", 1'b1, 3'b111, 1'b0, 1'b1, 2'd3);
    check("b2b_inrdy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    chk_out("b2b_3", 1'b1, 3'b001, 1'b1, 1'b1, 2'd1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("b2b_idle", 32'(bus.out_valid), 32'd0);

    // reset mid-sequence
    bus.in_valid = 1'b1; bus.in_data = 8'h80;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk_out("mr_c1", 1'b1, 3'b000, 1'b0, 1'b0, 2'd3);
    reset_n = 1'b0;
    #1 check("mr_drop", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("mr_rel_valid", 32'(bus.out_valid), 32'd0);
    run_vec("mr_v02", 8'h02, 1, 3'b010, 3'b000, 3'b000);

    // full sweep: rebuild each value from emitted chunks
    for (int i = 0; i < 256; i++) begin
      sv = int'($signed(8'(i)));
      exp_n = (sv >= -4 && sv <= 3) ? 1 : ((sv >= -32 && sv <= 31) ? 2 : 3);
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_data = 8'(i); bus.out_ready = 1'b1;
      v = 0; got_n = 0; done = 1'b0;
      for (int c = 0; c < 4 && !done; c++) begin
        @(negedge clk);
        if (c == 0) bus.in_valid = 1'b0;
        if (bus.out_valid) begin
          if (bus.out_first) v = int'($signed(bus.out_chunk));
          else               v = (v <<< 3) | int'(bus.out_chunk);
          got_n++;
          if (bus.out_last) done = 1'b1;
        end
      end
      check("sweep_done", 32'(done), 32'd1);
      check("sweep_val", 32'(v), 32'(sv));
      check("sweep_n", 32'(got_n), 32'(exp_n));
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imm_chunker.md
# imm_chunker

Immediate encoder for the datapath's instruction-build path: accepts an 8-bit two's-complement constant and emits it as the minimal sequence of 3-bit immediate chunks that the 3-to-8-bit sign-extension path reconstructs. Reconstruction rule: the first chunk is sign-extended, and each following chunk is appended as v = (v << 3) | chunk. It sits between the constant source (assembler/loader) and the instruction word builder, with valid/ready handshakes on both sides.

## Interface
- No parameters; widths are fixed at 8-bit value and 3-bit chunk.
- clk      input   1  rising-edge clock
- reset_n  input   1  asynchronous, active-low reset
- in_valid   input   1  constant available on in_data
- in_ready   output  1  block can accept a constant this cycle
- in_data    input   8  signed constant to encode
- out_valid  output  1  out_chunk/out_first/out_last/out_count valid
- out_ready  input   1  consumer accepts the current chunk
- out_chunk  output  3  current 3-bit immediate field
- out_first  output  1  chunk is the first of its constant (consumer sign-extends it)
- out_last   output  1  chunk is the final chunk of its constant
- out_count  output  2  total chunks for the current constant (1..3), stable for the whole sequence

## Operation
- Internal 9-bit value x = {in_data[7], in_data}, captured on an input handshake (in_valid & in_ready).
- Chunk count n is computed at capture from the signed value:
  - n = 1 for -4..3
  - n = 2 for -32..31 (excluding the n = 1 range)
  - n = 3 otherwise
- Chunk order, most significant first:
  - n = 3: x[8:6], x[5:3], x[2:0]
  - n = 2: x[5:3], x[2:0]
  - n = 1: x[2:0]
- State machine:
  - IDLE: out_valid = 0, in_ready = 1. An input handshake latches x, n and idx = 0, then goes to EMIT.
  - EMIT: out_valid = 1.
    - out_chunk is selected by n and idx.
    - out_first = (idx == 0); out_last = (idx == n-1).
    - On an output handshake (out_valid & out_ready) with out_last = 0: idx increments.
    - On an output handshake with out_last = 1: returns to IDLE, unless a new input is accepted in the same cycle (see below), in which case it stays in EMIT with the new x and n and idx = 0.
- in_ready = (state == IDLE) | (out_valid & out_ready & out_last). This is the only combinational input-to-output path; it allows back-to-back constants with no bubble.
- out_chunk, out_first, out_last and out_count come directly from registers plus a mux; in_data has no combinational path to the outputs.
- Outputs hold stable while out_valid = 1 and out_ready = 0.
- in_data is ignored when in_valid = 0 or in_ready = 0.

## Timing
- Reset (reset_n low, takes effect immediately, asynchronous):
  - state = IDLE, idx = 0, x = 0, n = 1
  - out_valid = 0, out_chunk = 3'b000, out_first = 0, out_last = 0, out_count = 2'd1, in_ready = 1 after release
- Latency: a constant accepted at edge T presents its first chunk with out_valid = 1 in the cycle after T.
- With out_ready held high, an n-chunk constant occupies n consecutive cycles.
- Sustained throughput: one chunk per cycle.
- Reset asserted mid-sequence: the remaining chunks are dropped. No partial sequence resumes after reset release.
- A last-chunk handshake and a new input handshake in the same cycle are legal. The next constant's first chunk appears in the following cycle.
- out_ready low on the last chunk: in_ready stays 0 and the pending input waits.

## Test plan
- Reset, then in_data = 8'h03 with out_ready = 1 → one cycle later: out_chunk = 3'b011, first = 1, last = 1, count = 1. Then IDLE with out_valid = 0.
- in_data = 8'hFC (-4) → single chunk 3'b100, count = 1. in_data = 8'h05 → chunks 3'b000 then 3'b101, count = 2.
- in_data = 8'hE0 (-32) → 3'b100, 3'b000 (count = 2). in_data = 8'h20 (+32) → 3'b000, 3'b100, 3'b000 (count = 3). in_data = 8'h80 (-128) → 3'b110, 3'b000, 3'b000.
- Backpressure: 8'h80 with out_ready low for 3 cycles on the second chunk → chunk 3'b000, first = 0, last = 0 held stable. in_ready = 0 throughout. The sequence completes after out_ready rises.
- Back-to-back: in_valid held high with 8'h7F then 8'h01, out_ready = 1 → outputs 3'b001, 3'b111, 3'b111, then 3'b001 (first = last = 1) with no idle cycle between constants.
- Reset asserted during the second chunk of 8'h80 → out_valid drops to 0 immediately. After release, 8'h02 → single chunk 3'b010. Scoreboard rebuilds every value via sext(first) then (v << 3) | chunk and compares it to the input for all 256 inputs.
